// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RISC-V core: opcodes, main FSM
// states, ALU operation classes and datapath mux select codes. The ALU decoder
// and the datapath muxes import this same package so the encodings live in one place.
package riscv_ctrl_pkg;

   // Opcode field instr[6:0] of the instruction classes the core executes
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   // Main FSM states; codes 11-15 are unused and fall back to FETCH
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   // ALU operation class handed to the ALU decoder
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Full control word decoded from the current state. pcUpdate and branch
   // stay internal to the FSM; only their combination reaches pc_write.
   typedef struct packed {
      logic [1:0] aluOp;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] resultSrc;
      logic       adrSrc;
      logic       irWrite;
      logic       regWrite;
      logic       memWrite;
      logic       pcUpdate;
      logic       branch;
   } ctrl_t;

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between the main FSM and the datapath. The FSM side (master)
// takes the opcode and zero flag and drives every select and write enable;
// the datapath side (slave) sees the mirror image.
interface main_fsm_if;

   logic [6:0] op;
   logic       zero;
   logic [1:0] alu_op;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic       adr_src;
   logic       ir_write;
   logic       reg_write;
   logic       mem_write;
   logic       pc_write;
   logic [3:0] state;

   modport master (
      input  op, zero,
      output alu_op, alu_src_a, alu_src_b, result_src, adr_src,
             ir_write, reg_write, mem_write, pc_write, state
   );

   modport slave (
      output op, zero,
      input  alu_op, alu_src_a, alu_src_b, result_src, adr_src,
             ir_write, reg_write, mem_write, pc_write, state
   );

endinterface

// File: rtl/main_fsm_outputs.sv
// Moore output decode for the main FSM: maps the current state onto the full
// control word. Purely combinational; anything not set for a state stays 0.
module main_fsm_outputs
   import riscv_ctrl_pkg::*;
(
   input  state_t state_i,
   output ctrl_t  ctrl_o
);

   // Decode the control word for the current state, all-zero by default
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.irWrite   = 1'b1;
            ctrl_o.aluSrcA   = SRCA_PC;
            ctrl_o.aluSrcB   = SRCB_FOUR;
            ctrl_o.resultSrc = RES_ALURESULT;
            ctrl_o.aluOp     = ALU_OP_ADD;
            ctrl_o.pcUpdate  = 1'b1;
         end
         S_DECODE: begin
            ctrl_o.aluSrcA = SRCA_OLDPC;
            ctrl_o.aluSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ctrl_o.aluSrcA = SRCA_RS1;
            ctrl_o.aluSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            ctrl_o.adrSrc = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl_o.adrSrc   = 1'b1;
            ctrl_o.memWrite = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.resultSrc = RES_MEMDATA;
            ctrl_o.regWrite  = 1'b1;
         end
         S_EXECUTER: begin
            ctrl_o.aluSrcA = SRCA_RS1;
            ctrl_o.aluSrcB = SRCB_RS2;
            ctrl_o.aluOp   = ALU_OP_FUNCT;
         end
         S_EXECUTEI: begin
            ctrl_o.aluSrcA = SRCA_RS1;
            ctrl_o.aluSrcB = SRCB_IMM;
            ctrl_o.aluOp   = ALU_OP_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.regWrite = 1'b1;
         end
         S_BEQ: begin
            ctrl_o.aluSrcA = SRCA_RS1;
            ctrl_o.aluOp   = ALU_OP_SUB;
            ctrl_o.branch  = 1'b1;
         end
         S_JAL: begin
            ctrl_o.aluSrcA  = SRCA_OLDPC;
            ctrl_o.aluSrcB  = SRCB_FOUR;
            ctrl_o.pcUpdate = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main control FSM: sequences each instruction through fetch,
// decode, execute, memory and writeback. Holds the state register and the
// next-state logic; the Moore decode lives in main_fsm_outputs. pc_write is
// the one Mealy term, since a taken branch must follow zero in the same cycle.
module main_fsm
   import riscv_ctrl_pkg::*;
(
   input logic        clk,
   input logic        rst_n,
   main_fsm_if.master bus
);

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl;

   // Next-state selection; unknown opcodes and unused codes return to FETCH
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTER;
               OP_IALU:      state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // State register; reset drops straight to FETCH so an in-flight write is cut off at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   main_fsm_outputs uOutputs (
      .state_i (state_q),
      .ctrl_o  (ctrl)
   );

   assign bus.alu_op     = ctrl.aluOp;
   assign bus.alu_src_a  = ctrl.aluSrcA;
   assign bus.alu_src_b  = ctrl.aluSrcB;
   assign bus.result_src = ctrl.resultSrc;
   assign bus.adr_src    = ctrl.adrSrc;
   assign bus.ir_write   = ctrl.irWrite;
   assign bus.reg_write  = ctrl.regWrite;
   assign bus.mem_write  = ctrl.memWrite;
   assign bus.pc_write   = ctrl.pcUpdate | (ctrl.branch & bus.zero);
   assign bus.state      = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed instruction sequences push the expected
// control word for every cycle into a queue; a monitor on the falling edge
// pops and compares against what the FSM presents.
module tb_main_fsm;

   logic clk;
   logic rst_n;

   main_fsm_if bus ();

   main_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   typedef struct packed {
      logic [3:0] st;
      logic [1:0] aluOp;
      logic [1:0] srcA;
      logic [1:0] srcB;
      logic [1:0] resSrc;
      logic       adr;
      logic       irw;
      logic       regw;
      logic       memw;
      logic       pcw;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   // Free-running 100 MHz-style clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-written expected control word for each state
   function automatic exp_t expFor(input logic [3:0] s, input logic z);
      exp_t e;
      e = '0;
      e.st = s;
      case (s)
         4'd0:  begin e.irw = 1'b1; e.srcB = 2'b10; e.resSrc = 2'b10; e.pcw = 1'b1; end
         4'd1:  begin e.srcA = 2'b01; e.srcB = 2'b01; end
         4'd2:  begin e.srcA = 2'b10; e.srcB = 2'b01; end
         4'd3:  begin e.adr = 1'b1; end
         4'd4:  begin e.resSrc = 2'b01; e.regw = 1'b1; end
         4'd5:  begin e.adr = 1'b1; e.memw = 1'b1; end
         4'd6:  begin e.srcA = 2'b10; e.aluOp = 2'b10; end
         4'd7:  begin e.regw = 1'b1; end
         4'd8:  begin e.srcA = 2'b10; e.srcB = 2'b01; e.aluOp = 2'b10; end
         4'd9:  begin e.srcA = 2'b01; e.srcB = 2'b10; e.pcw = 1'b1; end
         4'd10: begin e.srcA = 2'b10; e.aluOp = 2'b01; e.pcw = z; end
         default: e = '0;
      endcase
      return e;
   endfunction

   // Compare one expected record with the outputs currently on the bus
   task automatic checkOutput(input exp_t e);
      exp_t got;
      got = {bus.state, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.result_src,
             bus.adr_src, bus.ir_write, bus.reg_write, bus.mem_write, bus.pc_write};
      checks++;
      if (got !== e) begin
         errors++;
         $display("[TB] FAIL ctrl_state%0d at %0t: actual st=%0d aluOp=%b srcA=%b srcB=%b res=%b adr=%b ir=%b rw=%b mw=%b pcw=%b, required st=%0d aluOp=%b srcA=%b srcB=%b res=%b adr=%b ir=%b rw=%b mw=%b pcw=%b",
                  e.st, $time,
                  got.st, got.aluOp, got.srcA, got.srcB, got.resSrc, got.adr, got.irw, got.regw, got.memw, got.pcw,
                  e.st, e.aluOp, e.srcA, e.srcB, e.resSrc, e.adr, e.irw, e.regw, e.memw, e.pcw);
      end
   endtask

   // Monitor: away from the rising edge, compare against whatever is queued
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
      end
   end

   // Run one instruction: hold op/zero and queue the expected state walk.
   // seq packs the state codes one nibble per cycle, first cycle in the low nibble.
   task automatic applyStimulus(input logic [6:0] opc, input logic z, input int n, input logic [23:0] seq);
      bus.op   = opc;
      bus.zero = z;
      for (int i = 0; i < n; i++) begin
         expQ.push_back(expFor(seq[i*4 +: 4], z));
         @(posedge clk);
         #1;
      end
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus
   initial begin
      rst_n    = 1'b0;
      bus.op   = 7'b0110011;
      bus.zero = 1'b0;

      // Reset held for three cycles: FETCH decode throughout
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         expQ.push_back(expFor(4'd0, 1'b0));
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      applyStimulus(7'b0110011, 1'b1, 4, 24'h007610);   // R-type
      applyStimulus(7'b0000011, 1'b0, 5, 24'h043210);   // lw
      applyStimulus(7'b0100011, 1'b1, 4, 24'h005210);   // sw
      applyStimulus(7'b0010011, 1'b0, 4, 24'h007810);   // I-ALU
      applyStimulus(7'b1100011, 1'b1, 3, 24'h000A10);   // beq taken
      applyStimulus(7'b1100011, 1'b0, 3, 24'h000A10);   // beq not taken
      applyStimulus(7'b1101111, 1'b0, 4, 24'h007910);   // jal
      applyStimulus(7'b1111111, 1'b1, 2, 24'h000010);   // illegal opcode

      // sw aborted by reset in MEMWRITE: mem_write must drop before the next edge
      applyStimulus(7'b0100011, 1'b0, 3, 24'h000210);
      #1;
      rst_n = 1'b0;
      expQ.push_back(expFor(4'd0, 1'b0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      applyStimulus(7'b1111111, 1'b0, 2, 24'h000010);   // illegal after abort
      applyStimulus(7'b0000011, 1'b1, 5, 24'h043210);   // lw again
      expQ.push_back(expFor(4'd0, 1'b0));

      // Let the monitor drain the queue, bounded
      for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: actual %0d records left, required 0", expQ.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
